// File: rtl/scan_chain_loader_pkg.sv
// Shared types and constants for the scan-chain loader: FSM states, default chain geometry
// (31 memory cells + button bit + 7 LED bits), and the bit-counter width helper.
package scan_chain_loader_pkg;

  localparam int DEF_CELL_COUNT = 31;
  localparam int DEF_BYTE_WIDTH = 8;
  localparam int DEF_CHAIN_BITS = DEF_CELL_COUNT * 8 + 1 + 7;

  function automatic int cnt_width(input int bits);
    return $clog2(bits + 1);
  endfunction

  localparam int BIT_CNT_W = cnt_width(DEF_CHAIN_BITS);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BYTE = 2'd1,
    SHIFT     = 2'd2,
    DONE      = 2'd3
  } state_t;

endpackage

// File: rtl/scan_chain_loader_if.sv
// Session control, byte-stream handshake, scan-chain and readback signals of scan_chain_loader.
// master = upstream byte source / bank side, slave = the loader itself.
interface scan_chain_loader_if
  import scan_chain_loader_pkg::*;
#(
  parameter int BYTE_WIDTH = DEF_BYTE_WIDTH
);
  logic                  start;
  logic                  busy;
  logic                  done;
  logic [BYTE_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic                  scan_enable;
  logic                  scan_data;
  logic                  scan_return;
  logic [BYTE_WIDTH-1:0] rd_data;
  logic                  rd_valid;

  modport master (
    output start, in_data, in_valid, scan_return,
    input  busy, done, in_ready, scan_enable, scan_data, rd_data, rd_valid
  );

  modport slave (
    input  start, in_data, in_valid, scan_return,
    output busy, done, in_ready, scan_enable, scan_data, rd_data, rd_valid
  );
endinterface

// File: rtl/scan_chain_loader_deser.sv
// Readback byte assembler: collects chain-tail bits MSB first and emits one byte per 8 samples.
// Only instantiated when SCAN_CHAIN_LOADER_READBACK_EN is defined.
module scan_deserializer #(
  parameter int BYTE_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_clear,
  input  logic                  i_sample,
  input  logic                  i_bit,
  output logic [BYTE_WIDTH-1:0] o_data,
  output logic                  o_valid
);
  localparam int                IDX_W    = $clog2(BYTE_WIDTH);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(BYTE_WIDTH - 1);

  logic [BYTE_WIDTH-1:0] r_sh_p0;
  logic [IDX_W-1:0]      r_cnt_p0;
  logic [BYTE_WIDTH-1:0] r_rd_data_p1;
  logic                  r_rd_vld_p1;
  logic [BYTE_WIDTH-1:0] w_assembled;
  logic                  w_byte_full;

  assign w_assembled = {r_sh_p0[BYTE_WIDTH-2:0], i_bit};
  assign w_byte_full = i_sample && (r_cnt_p0 == LAST_IDX);

  // stage 0: sample the chain tail
  always_ff @(posedge clk) begin
    if (i_sample) r_sh_p0 <= w_assembled;
  end

  always_ff @(posedge clk) begin
    if (rst || i_clear) r_cnt_p0 <= '0;
    else if (i_sample)  r_cnt_p0 <= r_cnt_p0 + IDX_W'(1);
  end

  // stage 1: publish the completed byte
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_vld_p1  <= 1'b0;
      r_rd_data_p1 <= '0;
    end else begin
      r_rd_vld_p1 <= w_byte_full;
      if (w_byte_full) r_rd_data_p1 <= w_assembled;
    end
  end

  assign o_data  = r_rd_data_p1;
  assign o_valid = r_rd_vld_p1;
endmodule

// File: rtl/scan_chain_loader.sv
// Byte-stream to scan-chain serializer: one byte per handshake, shifted MSB first while scan_enable.
// Define SCAN_CHAIN_LOADER_READBACK_EN to deserialize the bits returning from the chain tail.
module scan_chain_loader
  import scan_chain_loader_pkg::*;
#(
  parameter int CHAIN_BITS = DEF_CHAIN_BITS,
  parameter int BYTE_WIDTH = DEF_BYTE_WIDTH
) (
  input logic                clk,
  input logic                rst,
  scan_chain_loader_if.slave bus
);
  localparam int               CNT_W    = cnt_width(CHAIN_BITS);
  localparam int               IDX_W    = $clog2(BYTE_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_BITS - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTE_WIDTH - 1);

  state_t                r_state;
  state_t                w_next;
  logic [BYTE_WIDTH-1:0] r_shreg;
  logic [CNT_W-1:0]      r_bit_cnt;
  logic [IDX_W-1:0]      r_byte_cnt;
  logic                  w_accept;
  logic                  w_shifting;
  logic                  w_byte_end;

  assign w_accept   = (r_state == WAIT_BYTE) && bus.in_valid;
  assign w_shifting = (r_state == SHIFT);
  assign w_byte_end = w_shifting && (r_byte_cnt == LAST_IDX);

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      if (bus.start) w_next = WAIT_BYTE;
      WAIT_BYTE: if (bus.in_valid) w_next = SHIFT;
      SHIFT:     if (w_byte_end) w_next = (r_bit_cnt == LAST_BIT) ? DONE : WAIT_BYTE;
      DONE:      w_next = IDLE;
      default:   w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || ((r_state == IDLE) && bus.start)) begin
      r_bit_cnt  <= '0;
      r_byte_cnt <= '0;
    end else if (w_shifting) begin
      r_bit_cnt  <= r_bit_cnt + CNT_W'(1);
      r_byte_cnt <= r_byte_cnt + IDX_W'(1);
    end
  end

  // Data path carries no reset; scan_data is gated by state so it reads 0 outside SHIFT.
  always_ff @(posedge clk) begin
    if (w_accept)        r_shreg <= bus.in_data;
    else if (w_shifting) r_shreg <= {r_shreg[BYTE_WIDTH-2:0], 1'b0};
  end

  assign bus.busy        = (r_state != IDLE);
  assign bus.done        = (r_state == DONE);
  assign bus.in_ready    = (r_state == WAIT_BYTE);
  assign bus.scan_enable = w_shifting;
  assign bus.scan_data   = w_shifting && r_shreg[BYTE_WIDTH-1];

`ifdef SCAN_CHAIN_LOADER_READBACK_EN
  logic w_session_end;
  assign w_session_end = (r_state == DONE);

  scan_deserializer #(.BYTE_WIDTH(BYTE_WIDTH)) u_deser (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (w_session_end),
    .i_sample (w_shifting),
    .i_bit    (bus.scan_return),
    .o_data   (bus.rd_data),
    .o_valid  (bus.rd_valid)
  );
`else
  logic w_unused_return;
  assign w_unused_return = bus.scan_return;
  assign bus.rd_data     = '0;
  assign bus.rd_valid    = 1'b0;
`endif
endmodule

// File: tb/tb_scan_chain_loader.sv
// Directed bench for scan_chain_loader with a behavioural 256-bit bank chain and scan/readback scoreboards.
module tb_scan_chain_loader;
  import scan_chain_loader_pkg::*;

  localparam int CB    = DEF_CHAIN_BITS;
  localparam int BW    = DEF_BYTE_WIDTH;
  localparam int NB    = CB / BW;
  localparam int LIMIT = 2000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  scan_chain_loader_if #(.BYTE_WIDTH(BW)) bus ();

  scan_chain_loader #(.CHAIN_BITS(CB), .BYTE_WIDTH(BW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // bank scan chain: scan_in enters at bit 0, tail (LED end) is the MSB
  logic [CB-1:0] bank = '0;
  always @(posedge clk) if (bus.scan_enable === 1'b1) bank <= {bank[CB-2:0], bus.scan_data};
  assign bus.scan_return = bank[CB-1];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int se_cnt = 0, done_cnt = 0, rd_cnt = 0;
  bit rd_check = 1'b0;
  bit exp_bits [$];
  logic [BW-1:0] exp_rd [$];
  logic [BW-1:0] pat [NB];
  logic [CB-1:0] ref1;
  int lat, se0, d0, rd0;

  task automatic check(input string tag, input logic [CB-1:0] obs, input logic [CB-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [CB-1:0] chain_of();
    logic [CB-1:0] c;
    c = '0;
    for (int i = 0; i < NB; i++) c = {c[CB-BW-1:0], pat[i]};
    return c;
  endfunction

  // one cycle: advance to the falling edge and run the output scoreboards
  task automatic step();
    bit       b;
    logic [BW-1:0] r;
    @(negedge clk);
    cyc++;
    if (bus.scan_enable === 1'b1) begin
      se_cnt++;
      if (exp_bits.size() == 0) check("scan_bit_unexpected", 1'b1, 1'b0);
      else begin
        b = exp_bits.pop_front();
        check("scan_bit", bus.scan_data, b);
      end
    end
    if (bus.done === 1'b1) done_cnt++;
    if (bus.rd_valid === 1'b1) begin
      rd_cnt++;
      if (rd_check) begin
        if (exp_rd.size() == 0) check("rd_unexpected", 1'b1, 1'b0);
        else begin
          r = exp_rd.pop_front();
          check("rd_data", bus.rd_data, r);
        end
      end
    end
  endtask

  task automatic run_session(input int gap_after, input int gap_len, input bit spam,
                             input int abort_bit, output int latency);
    int t0;
    bit ok;
    ok = 1'b1;
    latency = -1;
    t0 = cyc;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < NB; i++) begin
      bus.start    = spam && (i >= 5) && (i < 8);
      bus.in_data  = pat[i];
      bus.in_valid = 1'b1;
      while (ok && bus.in_ready !== 1'b1) begin
        step();
        if (cyc - t0 > LIMIT) ok = 1'b0;
      end
      if (!ok) break;
      for (int b = BW - 1; b >= 0; b--) exp_bits.push_back(pat[i][b]);
      step();
      bus.in_valid = 1'b0;
      if (abort_bit >= 0 && i == abort_bit / BW) begin
        repeat (abort_bit % BW) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.start = 1'b0;
        exp_bits.delete();
        return;
      end
      if (i == gap_after) begin
        while (ok && bus.in_ready !== 1'b1) begin
          step();
          if (cyc - t0 > LIMIT) ok = 1'b0;
        end
        repeat (gap_len) begin
          step();
          check("gap_scan_enable", bus.scan_enable, 1'b0);
        end
      end
    end
    bus.start = 1'b0;
    while (ok && bus.done !== 1'b1) begin
      step();
      if (cyc - t0 > LIMIT) ok = 1'b0;
    end
    if (ok) latency = cyc - t0;
    else begin
      total++;
      bad++;
      $error("FAIL session_timeout observed=%0d cycles expected=done", cyc - t0);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    step();
    step();
    rst = 1'b0;
    step();
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_in_ready", bus.in_ready, 1'b0);
    check("rst_scan_enable", bus.scan_enable, 1'b0);
    check("rst_scan_data", bus.scan_data, 1'b0);
    check("rst_rd_valid", bus.rd_valid, 1'b0);
    check("rst_rd_data", bus.rd_data, '0);

    // full load of 0x00..0x1F with in_valid held
    for (int i = 0; i < NB; i++) pat[i] = BW'(i);
    ref1 = chain_of();
    se0 = se_cnt; d0 = done_cnt;
    run_session(-1, 0, 1'b0, -1, lat);
    check("t1_latency", lat, 289);
    check("t1_busy_at_done", bus.busy, 1'b1);
    check("t1_cell0", bank[7:0], 8'h1F);
    check("t1_led", bank[CB-1:CB-7], 7'h00);
    check("t1_chain", bank, ref1);
    step();
    check("t1_scan_cycles", se_cnt - se0, CB);
    check("t1_done_pulses", done_cnt - d0, 1);
    check("t1_busy_after", bus.busy, 1'b0);
    check("t1_bits_left", exp_bits.size(), 0);

    // back-pressure: 5 idle cycles between bytes 3 and 4
    se0 = se_cnt;
    run_session(3, 5, 1'b0, -1, lat);
    check("t2_latency", lat, 294);
    check("t2_chain", bank, ref1);
    step();
    check("t2_scan_cycles", se_cnt - se0, CB);

    // start held high mid-session must be ignored
    for (int i = 0; i < NB; i++) pat[i] = BW'(8'hA5 ^ (i * 7));
    se0 = se_cnt; d0 = done_cnt;
    run_session(-1, 0, 1'b1, -1, lat);
    check("t3_latency", lat, 289);
    check("t3_chain", bank, chain_of());
    step();
    step();
    check("t3_scan_cycles", se_cnt - se0, CB);
    check("t3_done_pulses", done_cnt - d0, 1);
    check("t3_idle_busy", bus.busy, 1'b0);

    // reset at bit 100, then a clean reload
    for (int i = 0; i < NB; i++) pat[i] = ~BW'(i);
    run_session(-1, 0, 1'b0, 100, lat);
    check("t4_scan_enable", bus.scan_enable, 1'b0);
    check("t4_busy", bus.busy, 1'b0);
    check("t4_in_ready", bus.in_ready, 1'b0);
    check("t4_done", bus.done, 1'b0);
    se0 = se_cnt;
    step();
    step();
    check("t4_frozen", se_cnt - se0, 0);
    for (int i = 0; i < NB; i++) pat[i] = BW'(8'h3C + i * 3);
    run_session(-1, 0, 1'b0, -1, lat);
    check("t4_latency", lat, 289);
    check("t4_chain", bank, chain_of());
    step();

`ifdef SCAN_CHAIN_LOADER_READBACK_EN
    // chain holds pattern A; loading B must return A tail-first
    for (int i = 0; i < NB; i++) exp_rd.push_back(pat[i]);
    for (int i = 0; i < NB; i++) pat[i] = BW'(i * 17 + 5);
    rd_check = 1'b1;
    rd0 = rd_cnt;
    run_session(-1, 0, 1'b0, -1, lat);
    step();
    check("t5_rd_pulses", rd_cnt - rd0, NB);
    check("t5_rd_left", exp_rd.size(), 0);
    check("t5_chain", bank, chain_of());
    rd_check = 1'b0;
`else
    for (int i = 0; i < NB; i++) pat[i] = BW'(i);
    rd0 = rd_cnt;
    run_session(-1, 0, 1'b0, -1, lat);
    step();
    check("t6_rd_pulses", rd_cnt - rd0, 0);
    check("t6_rd_data", bus.rd_data, '0);
    check("t6_chain", bank, ref1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
